// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: instruction fields, memory handshake and control outputs of the multicycle controller
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero, mem_ready;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
  modport master (
    input op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           imm_src, alu_control, reg_write, illegal_op, state, retired
  );
  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
          imm_src, alu_control, reg_write, illegal_op, state, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32I multi-cycle sequencer with mem_ready stalls and retired-instruction count
module multicycle_control_fsm #(
  parameter int CNT_W = 32,
  parameter bit FETCH_ONLY_RESET = 1'b1
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10
  } state_t;
  // FETCH is the only supported restart point
  localparam state_t RESET_STATE = FETCH_ONLY_RESET ? FETCH : FETCH;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_FUNCT = 2'd2;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, BRANCH = 7'b1100011, JALOP = 7'b1101111;
  state_t state, next;
  logic [CNT_W-1:0] retired;
  logic retire, legal, pc_w, ir_w, reg_w, mem_w, ill;
  logic [1:0] alu_op, result_src, alu_src_a, alu_src_b, imm_src;
  logic adr_src;
  logic [2:0] funct_ctl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RESET_STATE;
      retired <= '0;
    end else begin
      state <= next;
      retired <= retired + CNT_W'(retire);
    end
  assign legal = bus.op == LW || bus.op == SW || bus.op == RTYPE || bus.op == ITYPE ||
                 bus.op == BRANCH || bus.op == JALOP;
  assign retire = state == MEMWB || state == ALUWB || state == BEQ || (state == MEMWRITE && bus.mem_ready);
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = bus.mem_ready ? DECODE : FETCH;
      DECODE:   next = (bus.op == LW || bus.op == SW) ? MEMADR :
                       bus.op == RTYPE ? EXECR : bus.op == ITYPE ? EXECI :
                       bus.op == BRANCH ? BEQ : bus.op == JALOP ? JAL : FETCH;
      MEMADR:   next = bus.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: next = bus.mem_ready ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: next = ALUWB;
      default:  next = FETCH;
    endcase
  end
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    ill = 1'b0;
    adr_src = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    imm_src = 2'b00;
    alu_op = OP_ADD;
    case (state)
      FETCH: begin
        ir_w = bus.mem_ready;
        pc_w = bus.mem_ready;
        alu_src_b = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = 2'b10;
        ill = !legal;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src = {1'b0, bus.op[5]};
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op = OP_FUNCT;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = OP_FUNCT;
      end
      ALUWB: reg_w = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op = OP_SUB;
        pc_w = bus.zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src = 2'b11;
        pc_w = 1'b1;
      end
      default: ;
    endcase
  end
  // sub only for R-type (op[5]=1); addi ignores instr[30]
  assign funct_ctl = bus.funct3 == 3'b000 ? ((bus.funct7b5 && bus.op[5]) ? 3'b001 : 3'b000) :
                     bus.funct3 == 3'b010 ? 3'b101 : bus.funct3 == 3'b110 ? 3'b011 :
                     bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign bus.alu_control = alu_op == OP_FUNCT ? funct_ctl : alu_op == OP_SUB ? 3'b001 : 3'b000;
  assign bus.pc_write = pc_w & rst_n;
  assign bus.ir_write = ir_w & rst_n;
  assign bus.reg_write = reg_w & rst_n;
  assign bus.mem_write = mem_w & rst_n;
  assign bus.illegal_op = ill & rst_n;
  assign bus.adr_src = adr_src;
  assign bus.result_src = result_src;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.imm_src = imm_src;
  assign bus.state = state;
  assign bus.retired = retired;
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle controller for the RV32I core, the sequenced counterpart to the single-cycle control unit. It steps the shared datapath (one ALU, one unified instruction/data memory) through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. It issues the per-state selects and write enables and stalls on a memory-ready handshake. It also flags unsupported opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
FETCH_ONLY_RESET, 1, when 1, the FSM always restarts in FETCH after reset (no other reset state is supported)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  0 = address from PC, 1 = address from ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR and OldPC enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  out  2  00 RD2, 01 Imm, 10 constant 4
imm_src  out  2  00 I, 01 S, 10 B, 11 J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
reg_write  out  1  register file write enable
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state  out  4  current state, for debug
retired  out  CNT_W  count of instructions completed

Behaviour:
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Encodings 11-15 are unreachable and go to FETCH.
- Reset (rst_n=0, asynchronous): state=FETCH, retired=0. pc_write, ir_write, reg_write, mem_write and illegal_op are forced to 0 while rst_n=0. All other outputs take their FETCH values.
- Outputs are Moore decoded from state. The exceptions are pc_write (depends on zero and mem_ready), ir_write and the FETCH exit (both gated by mem_ready). Any output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp add, result_src=10. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp add, imm_src=10 (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> FETCH, with illegal_op=1 for this cycle
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp add, imm_src=00 for lw and 01 for sw. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: result_src=00, adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Go to FETCH; retired+1.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 every cycle in this state. Hold until mem_ready, then go to FETCH; retired+1.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp funct. Go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, ALUOp funct. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH; retired+1.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp sub, result_src=00, pc_write=zero. Go to FETCH; retired+1.
- JAL: alu_src_a=01, alu_src_b=10, ALUOp add, result_src=00, pc_write=1, imm_src=11. Go to ALUWB. The retired increment happens in ALUWB only, so JAL counts once.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp funct, by funct3:
    - 000 -> 001 (sub) only when funct7b5=1 and op[5]=1; otherwise 000 (add)
    - 010 -> 101 (slt)
    - 110 -> 011 (or)
    - 111 -> 010 (and)
    - other funct3 -> 000, no flag
- retired wraps from all-ones to 0 and never saturates.
- Reset asserted mid-instruction, including a pending memory wait, aborts immediately. Re-entry is always at FETCH.
- CPI: lw=5, sw=4, R/I-type=4, beq=3, jal=4, each plus mem_ready stall cycles.

Test Plan:
- Reset, then lw (op=0000011) with mem_ready=1 -> states 0,1,2,3,4,0. reg_write=1 only in MEMWB, result_src=01 there. retired=1.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, adr_src=1, state stays 5 and then goes to 0. retired+1.
- R-type funct3=000, funct7b5=1 -> alu_control=001 in EXECR. With funct7b5=0 -> 000. For EXECI (op=0010011) with funct7b5=1 and funct3=000 -> 000 (op[5]=0).
- beq with zero=1 -> pc_write=1 in BEQ. With zero=0 -> pc_write=0. Both take 3 cycles with mem_ready=1.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0, state=0. Then mem_ready=1 -> ir_write=1 and pc_write=1 for one cycle, next state=1.
- op=1111111 in DECODE -> illegal_op pulse for 1 cycle, state goes to 0, retired unchanged. Then rst_n low during MEMREAD -> state=0 and all write enables 0 immediately, without waiting for clk.
